// File: rtl/srl_fifo_ctrl_pkg.sv
// Shared sizing helpers for shift-store FIFOs.
// Tap-address and level widths derived from store depth.
package srl_fifo_ctrl_pkg;

  function automatic int aw_of(input int dep);
    return (dep > 2) ? $clog2(dep) : 1;
  endfunction

  function automatic int cw_of(input int dep);
    return $clog2(dep + 1);
  endfunction

  function automatic int lw_of(input int dep);
    return $clog2(dep + 2);
  endfunction

endpackage

// File: rtl/srl_fifo_ctrl_if.sv
// Write/read valid-ready bundle for the SRL FIFO.
// master drives writes and consumes reads; slave is the FIFO.
interface srl_fifo_ctrl_if #(
  parameter int WID = 8
);
  logic           wr;
  logic [WID-1:0] wr_data;
  logic           wr_ready;
  logic           rd_valid;
  logic [WID-1:0] rd_data;
  logic           rd_ready;

  modport master (
    output wr, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/srl_fifo_ctrl_vtdl.sv
// Variable-tap delay line: shifts d in at tap 0 on ce.
// Output is a combinational read of tap a.
module vtdl
  import srl_fifo_ctrl_pkg::*;
#(
  parameter int WID = 8,
  parameter int DEP = 16,
  parameter int AW  = aw_of(DEP)
) (
  input  logic           clk,
  input  logic           ce,
  input  logic [AW-1:0]  a,
  input  logic [WID-1:0] d,
  output logic [WID-1:0] q
);

  logic [WID-1:0] mem [DEP];

  always_ff @(posedge clk) begin
    if (ce) begin
      mem[0] <= d;
      for (int i = 1; i < DEP; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign q = mem[a];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// FWFT FIFO controller: entry count, head register,
// bypass/refill, flags, flush and sticky overflow.
module srl_fifo_ctrl
  import srl_fifo_ctrl_pkg::*;
#(
  parameter int WID      = 8,
  parameter int DEP      = 16,
  parameter int AF_LEVEL = 14,
  localparam int AW      = aw_of(DEP),
  localparam int CW      = cw_of(DEP),
  localparam int LW      = lw_of(DEP)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  srl_fifo_ctrl_if.slave        bus,
  output logic [LW-1:0]         level,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  ovf
);

  logic [CW-1:0]  cnt;
  logic           head_v;
  logic [WID-1:0] head_d;
  logic [WID-1:0] tap_q;
  logic [AW-1:0]  tap;
  logic           cnt_z;
  logic           wr_ready;
  logic           push;
  logic           pop;
  logic           load;
  logic           ce;

  assign cnt_z    = (cnt == '0);
  assign wr_ready = !flush && (cnt != CW'(DEP));
  assign push     = bus.wr && wr_ready;
  assign pop      = head_v && bus.rd_ready;
  assign load     = !head_v || pop;
  // Words that bypass into an empty head never enter the store.
  assign ce       = push && !(load && cnt_z);
  assign tap      = cnt_z ? '0 : AW'(cnt - CW'(1));

  vtdl #(
    .WID (WID),
    .DEP (DEP)
  ) u_store (
    .clk (clk),
    .ce  (ce),
    .a   (tap),
    .d   (bus.wr_data),
    .q   (tap_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      head_v <= 1'b0;
      head_d <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      cnt    <= '0;
      head_v <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (bus.wr && !wr_ready) begin
        ovf <= 1'b1;
      end
      if (load) begin
        if (!cnt_z) begin
          head_d <= tap_q;
          head_v <= 1'b1;
          cnt    <= cnt - CW'(1) + CW'(push);
        end else if (push) begin
          head_d <= bus.wr_data;
          head_v <= 1'b1;
        end else begin
          head_v <= 1'b0;
        end
      end else begin
        cnt <= cnt + CW'(push);
      end
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.rd_valid = head_v;
  assign bus.rd_data  = head_d;

  assign level       = LW'(cnt) + LW'(head_v);
  assign empty       = (level == '0);
  assign almost_full = (level >= LW'(AF_LEVEL));

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Randomized and directed bench for srl_fifo_ctrl.
// Reference is a plain queue of the FIFO's contents.
module tb_srl_fifo_ctrl;

  localparam int WID = 8;
  localparam int DEP = 16;
  localparam int AFL = 14;
  localparam int LW  = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [LW-1:0] level;
  logic          empty;
  logic          almost_full;
  logic          ovf;

  srl_fifo_ctrl_if #(.WID(WID)) bus ();

  srl_fifo_ctrl #(
    .WID      (WID),
    .DEP      (DEP),
    .AF_LEVEL (AFL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .level       (level),
    .empty       (empty),
    .almost_full (almost_full),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [WID-1:0] mq[$];
  logic [WID-1:0] m_last;
  logic           m_ovf;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r,
                      input logic f,
                      input logic w,
                      input logic [WID-1:0] d,
                      input logic rr);
    int sz;
    bit rdy;
    rst_n       = r;
    flush       = f;
    bus.wr      = w;
    bus.wr_data = d;
    bus.rd_ready = rr;
    #1;
    sz  = mq.size();
    rdy = !f && (sz <= DEP);
    if (r) chk("wr_ready", 32'(bus.wr_ready), 32'(rdy));
    @(posedge clk);
    if (!r) begin
      mq.delete();
      m_last = '0;
      m_ovf  = 1'b0;
    end else if (f) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (w && !rdy) m_ovf = 1'b1;
      if (sz > 0 && rr) void'(mq.pop_front());
      if (w && rdy) mq.push_back(d);
      if (mq.size() > 0) m_last = mq[0];
    end
    @(negedge clk);
    sz = mq.size();
    chk("rd_valid", 32'(bus.rd_valid), 32'(sz > 0));
    chk("rd_data",  32'(bus.rd_data),  32'(m_last));
    chk("level",    32'(level),        32'(sz));
    chk("empty",    32'(empty),        32'(sz == 0));
    chk("almost_full", 32'(almost_full), 32'(sz >= AFL));
    chk("ovf",      32'(ovf),          32'(m_ovf));
  endtask

  task automatic idle(input logic rr);
    step(1'b1, 1'b0, 1'b0, '0, rr);
  endtask

  task automatic put(input logic [WID-1:0] d, input logic rr);
    step(1'b1, 1'b0, 1'b1, d, rr);
  endtask

  task automatic do_flush();
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
  endtask

  int pw;
  int pr;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.wr = 1'b0;
    bus.wr_data = '0;
    bus.rd_ready = 1'b0;
    m_last = '0;
    m_ovf  = 1'b0;
    @(negedge clk);

    // reset held with a write pending
    step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    idle(1'b0);
    chk("rst_empty", 32'(empty), 32'd1);

    // single-word latency
    put(8'hA5, 1'b0);
    chk("a5_head", 32'(bus.rd_data), 32'hA5);
    idle(1'b0);

    // fill to full, overflow, drain in order
    do_flush();
    for (int i = 0; i <= DEP; i++) put(8'(i), 1'b0);
    chk("full_level", 32'(level), 32'(DEP + 1));
    put(8'h55, 1'b0);
    chk("ovf_set", 32'(ovf), 32'd1);
    put(8'h56, 1'b1);
    for (int i = 0; i <= DEP + 1; i++) idle(1'b1);
    chk("drain_ovf", 32'(ovf), 32'd1);
    do_flush();

    // streaming at constant level
    for (int i = 0; i < 5; i++) put(8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      put(8'(8'h25 + i), 1'b1);
      chk("stream_level", 32'(level), 32'd5);
    end

    // flush with concurrent write and read
    do_flush();
    for (int i = 0; i < 8; i++) put(8'(8'h80 + i), 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'hEE, 1'b1);
    chk("flush_level", 32'(level), 32'd0);
    put(8'h3C, 1'b0);
    chk("post_flush", 32'(bus.rd_data), 32'h3C);

    // random traffic, alternating write- and read-heavy phases
    for (int ph = 0; ph < 6; ph++) begin
      pw = (ph % 2 == 0) ? 80 : 30;
      pr = (ph % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 400; i++) begin
        step(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 99) == 0),
             ($urandom_range(0, 99) < pw),
             8'($urandom),
             ($urandom_range(0, 99) < pr));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
